// File: rtl/ika87ad_busbridge.sv
// CPU-to-memory bus bridge: decodes ROM/RAM/IO windows, issues a level request
// with a bounded wait for acknowledge, and stalls the CPU clock enable meanwhile.
module ika87ad_busbridge #(
  parameter logic [15:0] ROM_TOP  = 16'h0FFF,
  parameter logic [15:0] RAM_BASE = 16'hFF00,
  parameter logic [15:0] IO_ADDR  = 16'h1401,
  parameter logic [7:0]  OPEN_BUS = 8'hFF,
  parameter logic [7:0]  TIMEOUT  = 8'd63
) (
  input  logic        i_EMUCLK,
  input  logic        i_RST,
  input  logic        i_PCEN_RAW,
  output logic        o_PCEN,
  input  logic [15:0] i_A,
  input  logic        i_RD_n,
  input  logic        i_WR_n,
  input  logic [7:0]  i_DO,
  output logic [7:0]  o_DI,
  output logic        o_MEM_REQ,
  output logic        o_MEM_WE,
  output logic [1:0]  o_MEM_SEL,
  output logic [15:0] o_MEM_ADDR,
  output logic [7:0]  o_MEM_WDATA,
  input  logic        i_MEM_ACK,
  input  logic [7:0]  i_MEM_RDATA,
  output logic        o_TIMEOUT
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_HOLD = 2'd2;

  localparam logic [1:0] SEL_NONE = 2'd0;
  localparam logic [1:0] SEL_ROM  = 2'd1;
  localparam logic [1:0] SEL_RAM  = 2'd2;
  localparam logic [1:0] SEL_IO   = 2'd3;

  logic [1:0]  state_q, state_d;
  logic        rd_n_q, wr_n_q;
  logic [7:0]  cnt_q, cnt_d;
  logic [7:0]  di_q, di_d;
  logic        req_q, req_d;
  logic        we_q, we_d;
  logic [1:0]  sel_q, sel_d;
  logic [15:0] addr_q, addr_d;
  logic [7:0]  wdata_q, wdata_d;
  logic        timeout_q, timeout_d;

  logic [1:0]  sel_dec;
  logic        rd_start, wr_start, strobe_start, issue, busy;

  always_comb begin
    if (i_A <= ROM_TOP)       sel_dec = SEL_ROM;
    else if (i_A >= RAM_BASE) sel_dec = SEL_RAM;
    else if (i_A == IO_ADDR)  sel_dec = SEL_IO;
    else                      sel_dec = SEL_NONE;
  end

  assign rd_start     = ~i_RD_n & rd_n_q;
  assign wr_start     = ~i_WR_n & wr_n_q;
  assign strobe_start = rd_start | wr_start;
  // A simultaneous read/write start is a write; ROM writes never reach the bus.
  assign issue = strobe_start && (sel_dec != SEL_NONE) && !(wr_start && sel_dec == SEL_ROM);
  assign busy  = (state_q == ST_REQ) || (state_q == ST_IDLE && issue);

  assign o_PCEN = i_PCEN_RAW & ~busy & ~i_RST;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    di_d      = di_q;
    req_d     = req_q;
    we_d      = we_q;
    sel_d     = sel_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    timeout_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (strobe_start) begin
          if (issue) begin
            addr_d  = i_A;
            wdata_d = i_DO;
            we_d    = wr_start;
            sel_d   = sel_dec;
            req_d   = 1'b1;
            cnt_d   = '0;
            state_d = ST_REQ;
          end else begin
            if (!wr_start) di_d = OPEN_BUS;
            state_d = ST_HOLD;
          end
        end
      end
      ST_REQ: begin
        if (i_MEM_ACK) begin
          req_d = 1'b0;
          if (!we_q) di_d = i_MEM_RDATA;
          state_d = ST_HOLD;
        end else if (cnt_q + 8'd1 == TIMEOUT) begin
          req_d     = 1'b0;
          timeout_d = 1'b1;
          if (!we_q) di_d = OPEN_BUS;
          state_d = ST_HOLD;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      ST_HOLD: begin
        if (i_RD_n && i_WR_n) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_EMUCLK or posedge i_RST) begin
    if (i_RST) begin
      state_q   <= ST_IDLE;
      rd_n_q    <= 1'b1;
      wr_n_q    <= 1'b1;
      cnt_q     <= '0;
      di_q      <= OPEN_BUS;
      req_q     <= 1'b0;
      we_q      <= 1'b0;
      sel_q     <= SEL_NONE;
      addr_q    <= '0;
      wdata_q   <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      rd_n_q    <= i_RD_n;
      wr_n_q    <= i_WR_n;
      cnt_q     <= cnt_d;
      di_q      <= di_d;
      req_q     <= req_d;
      we_q      <= we_d;
      sel_q     <= sel_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      timeout_q <= timeout_d;
    end
  end

  assign o_DI        = di_q;
  assign o_MEM_REQ   = req_q;
  assign o_MEM_WE    = we_q;
  assign o_MEM_SEL   = sel_q;
  assign o_MEM_ADDR  = addr_q;
  assign o_MEM_WDATA = wdata_q;
  assign o_TIMEOUT   = timeout_q;

endmodule

// File: tb/tb_ika87ad_busbridge.sv
// Randomized transaction-level bench for ika87ad_busbridge with a per-access
// behavioural prediction of request length, read data, timeout and PCEN gating.
module tb_ika87ad_busbridge;

  logic        clk = 1'b0;
  logic        i_RST, i_PCEN_RAW, o_PCEN;
  logic [15:0] i_A;
  logic        i_RD_n, i_WR_n;
  logic [7:0]  i_DO, o_DI;
  logic        o_MEM_REQ, o_MEM_WE;
  logic [1:0]  o_MEM_SEL;
  logic [15:0] o_MEM_ADDR;
  logic [7:0]  o_MEM_WDATA;
  logic        i_MEM_ACK;
  logic [7:0]  i_MEM_RDATA;
  logic        o_TIMEOUT;

  int checks = 0;
  int errors = 0;
  logic [7:0] model_di;

  always #5 clk = ~clk;

  ika87ad_busbridge #(
    .ROM_TOP(16'h0FFF), .RAM_BASE(16'hFF00), .IO_ADDR(16'h1401),
    .OPEN_BUS(8'hFF), .TIMEOUT(8'd63)
  ) dut (
    .i_EMUCLK(clk), .i_RST(i_RST), .i_PCEN_RAW(i_PCEN_RAW), .o_PCEN(o_PCEN),
    .i_A(i_A), .i_RD_n(i_RD_n), .i_WR_n(i_WR_n), .i_DO(i_DO), .o_DI(o_DI),
    .o_MEM_REQ(o_MEM_REQ), .o_MEM_WE(o_MEM_WE), .o_MEM_SEL(o_MEM_SEL),
    .o_MEM_ADDR(o_MEM_ADDR), .o_MEM_WDATA(o_MEM_WDATA),
    .i_MEM_ACK(i_MEM_ACK), .i_MEM_RDATA(i_MEM_RDATA), .o_TIMEOUT(o_TIMEOUT)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [1:0] ref_sel(input logic [15:0] a);
    if (a <= 16'h0FFF) return 2'd1;
    if (a >= 16'hFF00) return 2'd2;
    if (a == 16'h1401) return 2'd3;
    return 2'd0;
  endfunction

  // One CPU access held for 75 cycles. ack_dly = k means the memory acknowledges
  // in the k-th request cycle; 0 means it never answers.
  task automatic access(input logic [15:0] addr, input bit wr, input bit both,
                        input logic [7:0] wdata, input int ack_dly,
                        input logic [7:0] rdata, input bit poke);
    logic [1:0] sel;
    logic [7:0] exp_di;
    bit issue, is_wr, exp_to, exp_req, exp_pcen;
    int exp_len, di_cycle, req_cnt, to_cnt, to_at, req_bad, lat_bad, pcen_bad;
    sel     = ref_sel(addr);
    is_wr   = wr || both;
    issue   = (sel != 2'd0) && !(is_wr && sel == 2'd1);
    exp_to  = issue && (ack_dly <= 0 || ack_dly > 63);
    exp_len = !issue ? 0 : (exp_to ? 63 : ack_dly);
    if (is_wr)                exp_di = model_di;
    else if (!issue || exp_to) exp_di = 8'hFF;
    else                      exp_di = rdata;
    di_cycle = issue ? exp_len + 1 : 1;
    req_cnt = 0; to_cnt = 0; to_at = -1; req_bad = 0; lat_bad = 0; pcen_bad = 0;

    @(posedge clk); #1;
    i_A = addr; i_DO = wdata;
    i_RD_n = is_wr && !both;
    i_WR_n = !is_wr;
    for (int c = 0; c < 75; c++) begin
      i_PCEN_RAW  = 1'($urandom);
      i_MEM_RDATA = 8'($urandom);
      i_MEM_ACK   = 1'b0;
      if (poke && !both && c == 2) begin
        if (is_wr) i_RD_n = 1'b0; else i_WR_n = 1'b0;
      end
      if (poke && !both && c == 3) begin
        if (is_wr) i_RD_n = 1'b1; else i_WR_n = 1'b1;
      end
      @(negedge clk);
      exp_req  = issue && c >= 1 && c <= exp_len;
      exp_pcen = i_PCEN_RAW && !(issue && c <= exp_len);
      if (o_MEM_REQ) req_cnt++;
      if (o_MEM_REQ !== exp_req) req_bad++;
      if (exp_req && (o_MEM_ADDR !== addr || o_MEM_SEL !== sel || o_MEM_WE !== is_wr ||
                      (is_wr && o_MEM_WDATA !== wdata))) lat_bad++;
      if (o_PCEN !== exp_pcen) pcen_bad++;
      if (o_TIMEOUT === 1'b1) begin to_cnt++; to_at = c; end
      if (c == 0) chk("di_before", o_DI, model_di);
      if (c == di_cycle) chk("di_latency", o_DI, exp_di);
      if (issue && !exp_to && c == ack_dly) begin
        i_MEM_ACK = 1'b1; i_MEM_RDATA = rdata;
      end else if (c == 0 || c > exp_len) begin
        i_MEM_ACK = 1'($urandom);
      end
      @(posedge clk); #1;
    end
    i_MEM_ACK = 1'b0; i_RD_n = 1'b1; i_WR_n = 1'b1; i_PCEN_RAW = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("req_cycles", req_cnt, exp_len);
    chk("req_shape", req_bad, 0);
    chk("latched_fields", lat_bad, 0);
    chk("pcen_gating", pcen_bad, 0);
    chk("timeout_pulses", to_cnt, exp_to);
    if (exp_to) chk("timeout_cycle", to_at, exp_len + 1);
    chk("di_final", o_DI, exp_di);
    model_di = exp_di;
  endtask

  function automatic logic [15:0] rand_addr();
    case ($urandom_range(0, 9))
      0: return 16'h0FFF;
      1: return 16'h1000;
      2: return 16'hFEFF;
      3: return 16'hFF00;
      4: return 16'h1401;
      5: return 16'h1400;
      6: return 16'($urandom_range(0, 16'h0FFF));
      7: return 16'($urandom_range(16'hFF00, 16'hFFFF));
      8: return 16'($urandom);
      default: return 16'hFFFF;
    endcase
  endfunction

  initial begin
    int to_seen;
    i_RST = 1'b1; i_PCEN_RAW = 1'b1; i_A = '0; i_RD_n = 1'b1; i_WR_n = 1'b1;
    i_DO = '0; i_MEM_ACK = 1'b0; i_MEM_RDATA = '0;
    model_di = 8'hFF;
    repeat (3) @(negedge clk);
    chk("rst_req", o_MEM_REQ, 0);
    chk("rst_we", o_MEM_WE, 0);
    chk("rst_sel", o_MEM_SEL, 0);
    chk("rst_addr", o_MEM_ADDR, 0);
    chk("rst_wdata", o_MEM_WDATA, 0);
    chk("rst_di", o_DI, 8'hFF);
    chk("rst_timeout", o_TIMEOUT, 0);
    chk("rst_pcen", o_PCEN, 0);
    @(posedge clk); #1;
    i_RST = 1'b0; i_PCEN_RAW = 1'b0;
    repeat (3) @(posedge clk);

    access(16'h0010, 0, 0, 8'h00, 3, 8'h3C, 0);
    access(16'hFF20, 1, 0, 8'hA5, 1, 8'h00, 0);
    access(16'h1401, 0, 0, 8'h00, 1, 8'hEE, 0);
    access(16'h2000, 0, 0, 8'h00, 2, 8'h11, 0);
    access(16'hFF00, 0, 0, 8'h00, 0, 8'h22, 0);
    access(16'h0100, 1, 0, 8'h77, 1, 8'h00, 0);
    access(16'hFF01, 0, 1, 8'h5C, 2, 8'h00, 0);
    access(16'hFF10, 0, 0, 8'h00, 63, 8'h81, 1);
    access(16'h1401, 1, 0, 8'h42, 62, 8'h00, 1);

    // Reset in the middle of an unanswered read request.
    @(posedge clk); #1;
    i_A = 16'hFF00; i_RD_n = 1'b0; i_PCEN_RAW = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    chk("pre_rst_req", o_MEM_REQ, 1);
    i_RST = 1'b1;
    #1;
    chk("async_rst_req", o_MEM_REQ, 0);
    chk("async_rst_di", o_DI, 8'hFF);
    chk("async_rst_timeout", o_TIMEOUT, 0);
    chk("async_rst_pcen", o_PCEN, 0);
    i_RD_n = 1'b1; i_PCEN_RAW = 1'b0;
    @(posedge clk); #1;
    i_RST = 1'b0;
    i_MEM_ACK = 1'b1; i_MEM_RDATA = 8'h99;
    to_seen = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (o_TIMEOUT === 1'b1) to_seen++;
      @(posedge clk); #1;
      i_MEM_ACK = 1'b0;
    end
    chk("late_ack_di", o_DI, 8'hFF);
    chk("late_ack_req", o_MEM_REQ, 0);
    chk("rst_no_timeout", to_seen, 0);
    model_di = 8'hFF;
    access(16'hFF00, 0, 0, 8'h00, 2, 8'h5A, 0);

    for (int n = 0; n < 40; n++) begin
      int dly;
      case ($urandom_range(0, 7))
        0: dly = 0;
        1: dly = 63;
        2: dly = 62;
        default: dly = int'($urandom_range(1, 8));
      endcase
      access(rand_addr(), 1'($urandom), ($urandom_range(0, 5) == 0),
             8'($urandom), dly, 8'($urandom), 1'($urandom));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
